// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// The operands are cut into SEG_W-bit segments, and each pipeline stage adds one
// segment. A stage registers the carry out of its segment, and the next stage
// picks it up. A combinational valid/ready chain lets every stage advance in the
// same cycle, so the unit accepts one beat per cycle and adds no bubbles.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int NGRP = SEG_W / 4;

  // One segment of lookahead addition.
  // Each 4-bit group forms its own carries from bit-level p/g. The group
  // carry-ins come from a flat sum-of-products over the group P/G terms, so no
  // carry ripples from one group to the next.
  // Returned value: {carry out, carry into the segment MSB, segment sum}.
  function automatic logic [SEG_W+1:0] claSeg(
    input logic [SEG_W-1:0] x,
    input logic [SEG_W-1:0] y,
    input logic             ci
  );
    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] c;
    logic [SEG_W-1:0] s;
    logic [NGRP-1:0]  grpP;
    logic [NGRP-1:0]  grpG;
    logic [NGRP:0]    grpC;
    logic             term;
    logic             gci;
    int               base;

    p = x ^ y;
    g = x & y;

    // Group propagate is the AND of all four bits.
    // Group generate is the usual 4-term lookahead expression.
    for (int j = 0; j < NGRP; j++) begin
      base    = 4 * j;
      grpP[j] = p[base+3] & p[base+2] & p[base+1] & p[base];
      grpG[j] = g[base+3]
              | (p[base+3] & g[base+2])
              | (p[base+3] & p[base+2] & g[base+1])
              | (p[base+3] & p[base+2] & p[base+1] & g[base]);
    end

    // Carry into group j is an OR of product terms.
    // Every term is built directly from the group P/G values and ci.
    grpC[0] = ci;
    for (int j = 1; j <= NGRP; j++) begin
      term = ci;
      for (int m = 0; m < j; m++) begin
        term = term & grpP[m];
      end
      grpC[j] = term;
      for (int i = 0; i < j; i++) begin
        term = grpG[i];
        for (int m = i + 1; m < j; m++) begin
          term = term & grpP[m];
        end
        grpC[j] = grpC[j] | term;
      end
    end

    // Inside each group, every bit carry is written out in full lookahead form.
    for (int j = 0; j < NGRP; j++) begin
      base      = 4 * j;
      gci       = grpC[j];
      c[base]   = gci;
      c[base+1] = g[base] | (p[base] & gci);
      c[base+2] = g[base+1]
                | (p[base+1] & g[base])
                | (p[base+1] & p[base] & gci);
      c[base+3] = g[base+2]
                | (p[base+2] & g[base+1])
                | (p[base+2] & p[base+1] & g[base])
                | (p[base+2] & p[base+1] & p[base] & gci);
    end

    s = p ^ c;
    return {grpC[NGRP], c[SEG_W-1], s};
  endfunction

  // Per-stage state. Stage k holds:
  //   - the sum bits completed so far;
  //   - the carry out of segment k;
  //   - the operands, already B-inverted, for the stages still to come.
  logic [NSEG-1:0]  valid_q;
  logic [NSEG-1:0]  valid_d;
  logic [NSEG-1:0]  carry_q;
  logic [NSEG-1:0]  carry_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] a_d   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] b_d   [NSEG];
  logic [WIDTH-1:0] sum_q [NSEG];
  logic [WIDTH-1:0] sum_d [NSEG];

  // Values arriving at each stage's adder.
  // Stage 0 takes the module inputs; later stages take the previous stage's registers.
  logic [WIDTH-1:0] stgA   [NSEG];
  logic [WIDTH-1:0] stgB   [NSEG];
  logic [WIDTH-1:0] stgSum [NSEG];
  logic [SEG_W+1:0] segRes [NSEG];
  logic [NSEG-1:0]  stgC;
  logic [NSEG-1:0]  stgV;
  logic [NSEG:0]    stageEn;
  logic [WIDTH-1:0] bEff;
  logic             cinEff;

  // Work out the ready chain, route each stage's operands, and form next state.
  always_comb begin
    // A stage can load when it is empty, or when its contents move on this cycle.
    // The chain runs from the output back to the input, so it never looks at in_valid.
    stageEn[NSEG] = out_ready;
    for (int k = NSEG - 1; k >= 0; k--) begin
      stageEn[k] = !valid_q[k] || stageEn[k+1];
    end

    // Subtraction is a + ~b + 1. B is inverted once here, and cin is forced to 1.
    bEff   = sub ? ~b : b;
    cinEff = sub | cin;

    stgA[0]   = a;
    stgB[0]   = bEff;
    stgC[0]   = cinEff;
    stgSum[0] = '0;
    stgV[0]   = in_valid;
    for (int k = 1; k < NSEG; k++) begin
      stgA[k]   = a_q[k-1];
      stgB[k]   = b_q[k-1];
      stgC[k]   = carry_q[k-1];
      stgSum[k] = sum_q[k-1];
      stgV[k]   = valid_q[k-1];
    end

    valid_d = valid_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    for (int k = 0; k < NSEG; k++) begin
      a_d[k]    = a_q[k];
      b_d[k]    = b_q[k];
      sum_d[k]  = sum_q[k];
      segRes[k] = claSeg(stgA[k][k*SEG_W +: SEG_W], stgB[k][k*SEG_W +: SEG_W], stgC[k]);
    end

    // A stage that advances takes the valid bit from upstream.
    // Data registers load only for a real beat, so bubbles leave the data alone.
    for (int k = 0; k < NSEG; k++) begin
      if (stageEn[k]) begin
        valid_d[k] = stgV[k];
        if (stgV[k]) begin
          a_d[k]                      = stgA[k];
          b_d[k]                      = stgB[k];
          sum_d[k]                    = stgSum[k];
          sum_d[k][k*SEG_W +: SEG_W]  = segRes[k][SEG_W-1:0];
          carry_d[k]                  = segRes[k][SEG_W+1];
          if (k == NSEG - 1) begin
            ovf_d = segRes[k][SEG_W+1] ^ segRes[k][SEG_W];
          end
        end
      end
    end
  end

  // Pipeline registers.
  // Reset clears every beat in flight at once; a stalled stage keeps its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign in_ready  = stageEn[0];
  assign out_valid = valid_q[NSEG-1];
  assign sum       = sum_q[NSEG-1];
  assign cout      = carry_q[NSEG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: self-checking bench for cla_pipe_adder.
// The main instance is 32/8. Three extra instances, 4/4, 16/4 and 64/16, cover
// other parameter choices. Every result is compared with a plain-arithmetic
// reference model.
module tb_cla_pipe_adder;

  localparam int NSEG = 4;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        outValid;
  logic        outReady;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  logic        swValid;
  logic        swCin;
  logic        swSub;
  logic        swOutReady;
  logic [3:0]  s4a, s4b, s4Sum;
  logic        s4InReady, s4OutValid, s4Cout, s4Ovf;
  logic [15:0] s16a, s16b, s16Sum;
  logic        s16InReady, s16OutValid, s16Cout, s16Ovf;
  logic [63:0] s64a, s64b, s64Sum;
  logic        s64InReady, s64OutValid, s64Cout, s64Ovf;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          popCount = 0;
  int          swPops4 = 0, swPops16 = 0, swPops64 = 0;
  bit          strictLat = 0;
  bit          heldValid = 0;
  logic [65:0] heldVal;

  logic [65:0] expQ[$];
  int          edgeQ[$];
  logic [65:0] q4[$], q16[$], q64[$];
  int          t4[$], t16[$], t64[$];

  cla_pipe_adder #(.WIDTH(32), .SEG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(outValid), .out_ready(outReady),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_pipe_adder #(.WIDTH(4), .SEG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(swValid), .in_ready(s4InReady),
    .a(s4a), .b(s4b), .cin(swCin), .sub(swSub),
    .out_valid(s4OutValid), .out_ready(swOutReady),
    .sum(s4Sum), .cout(s4Cout), .ovf(s4Ovf)
  );

  cla_pipe_adder #(.WIDTH(16), .SEG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(swValid), .in_ready(s16InReady),
    .a(s16a), .b(s16b), .cin(swCin), .sub(swSub),
    .out_valid(s16OutValid), .out_ready(swOutReady),
    .sum(s16Sum), .cout(s16Cout), .ovf(s16Ovf)
  );

  cla_pipe_adder #(.WIDTH(64), .SEG_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(swValid), .in_ready(s64InReady),
    .a(s64a), .b(s64b), .cin(swCin), .sub(swSub),
    .out_valid(s64OutValid), .out_ready(swOutReady),
    .sum(s64Sum), .cout(s64Cout), .ovf(s64Ovf)
  );

  // Free-running clock, plus a count of rising edges used to measure latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: full-precision arithmetic truncated to w bits.
  // Returns {cout, ovf, sum zero-extended to 64 bits}.
  function automatic logic [65:0] refAdd(input int w, input logic [63:0] x,
                                         input logic [63:0] y, input logic ci,
                                         input logic sb);
    logic [63:0] mask, xm, ye, s;
    logic [64:0] full;
    logic        c, o;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    ye   = sb ? (~y & mask) : (y & mask);
    full = {1'b0, xm} + {1'b0, ye} + (sb ? 65'd1 : {64'd0, ci});
    s    = full[63:0] & mask;
    c    = full[w];
    o    = (xm[w-1] == ye[w-1]) && (s[w-1] != xm[w-1]);
    return {c, o, s};
  endfunction

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Main-instance scoreboard. At each negedge it checks:
  //   - in_ready against the occupancy;
  //   - held outputs stay stable while stalled;
  //   - results come out in order.
  // A transfer seen at this negedge happens at the following rising edge.
  always @(negedge clk) begin : mainMon
    logic [65:0] e;
    int          t;
    if (rst_n) begin
      checkOutput("inReady", inReady, (expQ.size() < NSEG) || outReady);
      checkOutput("inflight", expQ.size() <= NSEG, 1'b1);
      if (outValid && heldValid) checkOutput("stable", {cout, ovf, 32'd0, sum}, heldVal);
      if (outValid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious", outValid, 1'b0);
        end else if (outReady) begin
          e = expQ.pop_front();
          t = edgeQ.pop_front();
          checkOutput("result", {cout, ovf, 32'd0, sum}, e);
          if (strictLat) checkOutput("latency", cycle - t, NSEG - 1);
          popCount++;
        end
      end
      heldValid = outValid && !outReady;
      heldVal   = {cout, ovf, 32'd0, sum};
      if (inValid && inReady) begin
        expQ.push_back(refAdd(32, {32'd0, a}, {32'd0, b}, cin, sub));
        edgeQ.push_back(cycle + 1);
      end
    end
  end

  // Scoreboards for the parameter-sweep instances.
  // out_ready is held high for these, so every beat must emerge after exactly NSEG-1 more edges.
  always @(negedge clk) begin : sweepMon
    logic [65:0] e;
    int          t;
    if (rst_n) begin
      if (s4OutValid) begin
        if (q4.size() == 0) checkOutput("w4 spurious", 1'b1, 1'b0);
        else begin
          e = q4.pop_front(); t = t4.pop_front(); swPops4++;
          checkOutput("w4 result", {s4Cout, s4Ovf, 60'd0, s4Sum}, e);
          checkOutput("w4 latency", cycle - t, 0);
        end
      end
      if (s16OutValid) begin
        if (q16.size() == 0) checkOutput("w16 spurious", 1'b1, 1'b0);
        else begin
          e = q16.pop_front(); t = t16.pop_front(); swPops16++;
          checkOutput("w16 result", {s16Cout, s16Ovf, 48'd0, s16Sum}, e);
          checkOutput("w16 latency", cycle - t, 3);
        end
      end
      if (s64OutValid) begin
        if (q64.size() == 0) checkOutput("w64 spurious", 1'b1, 1'b0);
        else begin
          e = q64.pop_front(); t = t64.pop_front(); swPops64++;
          checkOutput("w64 result", {s64Cout, s64Ovf, s64Sum}, e);
          checkOutput("w64 latency", cycle - t, 3);
        end
      end
      if (swValid && s4InReady) begin
        q4.push_back(refAdd(4, {60'd0, s4a}, {60'd0, s4b}, swCin, swSub)); t4.push_back(cycle + 1);
      end
      if (swValid && s16InReady) begin
        q16.push_back(refAdd(16, {48'd0, s16a}, {48'd0, s16b}, swCin, swSub)); t16.push_back(cycle + 1);
      end
      if (swValid && s64InReady) begin
        q64.push_back(refAdd(64, s64a, s64b, swCin, swSub)); t64.push_back(cycle + 1);
      end
    end
  end

  // Drive one beat and hold it until it is accepted, then drop in_valid.
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                               input logic vc, input logic vs);
    bit took;
    took = 0;
    a = va; b = vb; cin = vc; sub = vs; inValid = 1'b1;
    for (int n = 0; n < 64 && !took; n++) begin
      @(negedge clk);
      if (inReady) took = 1;
    end
    if (!took) checkOutput("accept timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  // Send one vector with out_ready high.
  // Check the result against hand-computed constants, and count the cycles until it appears.
  task automatic runVector(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic vc, input logic vs, input logic [31:0] eSum,
                           input logic eCout, input logic eOvf);
    int n;
    bit seen;
    seen = 0; n = 0;
    applyStimulus(va, vb, vc, vs);
    while (n < 16 && !seen) begin
      @(negedge clk);
      n++;
      if (outValid) seen = 1;
    end
    if (!seen) checkOutput({tag, " timeout"}, 1'b0, 1'b1);
    else begin
      checkOutput(tag, {cout, ovf, sum}, {eCout, eOvf, eSum});
      checkOutput({tag, " cycles"}, n, NSEG);
    end
    @(posedge clk); #1;
  endtask

  // Wait, within a bound, for the main scoreboard to empty.
  task automatic drainPipe(input string tag);
    for (int n = 0; n < 40 && expQ.size() != 0; n++) @(posedge clk);
    #1;
    checkOutput(tag, expQ.size(), 0);
  endtask

  // Hard stop if something hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin : mainSeq
    int  nAcc;
    bit  acc;
    int  base;
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    swValid = 1'b0; swCin = 1'b0; swSub = 1'b0; swOutReady = 1'b1;
    s4a = '0; s4b = '0; s16a = '0; s16b = '0; s64a = '0; s64b = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outValid", outValid, 1'b0);
    checkOutput("reset sum", sum, 32'd0);
    checkOutput("reset cout", cout, 1'b0);
    checkOutput("reset ovf", ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("inReady after reset", inReady, 1'b1);
    @(posedge clk); #1;

    // Directed boundary vectors.
    outReady = 1'b1; strictLat = 1;
    runVector("add wrap",      32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    runVector("add ovf",       32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    runVector("add cin chain", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    runVector("sub borrow",    32'd5,         32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runVector("sub borrow c1", 32'd5,         32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runVector("sub ovf",       32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    runVector("sub ovf c1",    32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Back-to-back throughput with out_ready held high.
    base = popCount;
    inValid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      if (i % 50 == 0) begin a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; sub = 1'b0; end
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    drainPipe("throughput drain");
    checkOutput("throughput count", popCount - base, 1000);

    // Fill with out_ready low: exactly NSEG beats get in before in_ready drops.
    strictLat = 0;
    outReady = 1'b0; inValid = 1'b1; nAcc = 0;
    a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = inReady;
      if (acc) nAcc++;
      @(posedge clk); #1;
      if (acc) begin a = $urandom; b = $urandom; end
    end
    checkOutput("fill count", nAcc, NSEG);
    inValid = 1'b0; outReady = 1'b1;
    drainPipe("fill drain");

    // Random backpressure (~30% out_ready) with gaps in in_valid.
    // The source holds each beat until it is accepted.
    acc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!inValid || acc) begin
        inValid = ($urandom_range(0, 9) < 7);
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      outReady = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      acc = inValid && inReady;
      @(posedge clk); #1;
    end
    inValid = 1'b0; outReady = 1'b1;
    drainPipe("backpressure drain");

    // Reset mid-stream with three beats in flight.
    outReady = 1'b0; inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre-reset outValid", outValid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset outValid", outValid, 1'b0);
    checkOutput("async reset sum", sum, 32'd0);
    checkOutput("async reset cout", cout, 1'b0);
    checkOutput("async reset ovf", ovf, 1'b0);
    expQ.delete(); edgeQ.delete(); heldValid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("inReady after mid reset", inReady, 1'b1);
    checkOutput("no stale beat", outValid, 1'b0);
    @(posedge clk); #1;
    outReady = 1'b1; strictLat = 1;
    runVector("post-reset add", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Parameter sweep. The 4/4 instance sees all 1024 a/b/cin/sub combinations.
    // The wider instances get random data, plus all-ones carry chains.
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] idx;
      idx = 10'(i);
      swValid = 1'b1;
      s4a = idx[3:0]; s4b = idx[7:4]; swCin = idx[8]; swSub = idx[9];
      s16a = 16'($urandom); s16b = 16'($urandom);
      s64a = {$urandom, $urandom}; s64b = {$urandom, $urandom};
      if (i % 8 == 0) begin s16a = '1; s16b = 16'd1; s64a = '1; s64b = 64'd1; end
      if (i % 8 == 1) begin s16a = '1; s16b = '0;    s64a = '1; s64b = '0;    end
      @(posedge clk); #1;
    end
    swValid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("w4 count", swPops4, 1024);
    checkOutput("w16 count", swPops16, 1024);
    checkOutput("w64 count", swPops64, 1024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
